// File: rtl/cla_adder_pipe.sv
// Pipelined carry-look-ahead adder/subtractor. Each stage adds one SLICE-bit slice;
// the slice carry, the not-yet-added operand bits and the finished low sum bits move forward together.

module cla_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  localparam int GROUPS = SLICE / 4;

  logic [SLICE-1:0] g, p;
  logic [SLICE:0]   c;
  logic             gen_t, prop_t;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry inside a 4-bit group is a full look-ahead term on the group carry-in;
  // the group carry-outs then chain from one group to the next.
  always_comb begin
    c      = '0;
    gen_t  = 1'b0;
    prop_t = 1'b0;
    c[0]   = cin;
    for (int grp = 0; grp < GROUPS; grp++) begin
      for (int i = 0; i < 4; i++) begin
        gen_t = 1'b0;
        for (int j = 0; j <= i; j++) begin
          prop_t = g[grp*4+j];
          for (int m = j + 1; m <= i; m++) prop_t = prop_t & p[grp*4+m];
          gen_t = gen_t | prop_t;
        end
        prop_t = c[grp*4];
        for (int m = 0; m <= i; m++) prop_t = prop_t & p[grp*4+m];
        c[grp*4+i+1] = gen_t | prop_t;
      end
    end
  end

  assign sum   = p ^ c[SLICE-1:0];
  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];
endmodule

module cla_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int STAGES = WIDTH / SLICE;

  if ((SLICE != 4 && SLICE != 8 && SLICE != 16) || (WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_cfg
    $error("cla_adder_pipe: SLICE must be 4/8/16 and WIDTH a positive multiple of SLICE");
  end

  logic                         adv;
  logic [WIDTH-1:0]             b_eff;
  logic                         cin_eff;
  logic [STAGES-1:0]            vld_q, vld_d, c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                         ovf_q, ovf_d;
  logic [STAGES-1:0][SLICE-1:0] sl_a, sl_b, sl_s;
  logic [STAGES-1:0]            sl_ci, sl_co, sl_cm;
  logic                         unused_bits;

  // A single global enable: bubbles shift like data and nothing compacts.
  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;
  assign b_eff    = in_sub ? ~in_b : in_b;
  assign cin_eff  = in_sub | in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign sl_a[k]  = in_a[SLICE-1:0];
      assign sl_b[k]  = b_eff[SLICE-1:0];
      assign sl_ci[k] = cin_eff;
    end else begin : g_rest
      assign sl_a[k]  = a_q[k-1][k*SLICE +: SLICE];
      assign sl_b[k]  = b_q[k-1][k*SLICE +: SLICE];
      assign sl_ci[k] = c_q[k-1];
    end
    cla_slice #(.SLICE(SLICE)) u_slice (
      .a     (sl_a[k]),
      .b     (sl_b[k]),
      .cin   (sl_ci[k]),
      .sum   (sl_s[k]),
      .cout  (sl_co[k]),
      .c_msb (sl_cm[k])
    );
  end

  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    if (adv) begin
      vld_d[0]              = in_valid;
      a_d[0]                = in_a;
      b_d[0]                = b_eff;
      sum_d[0]              = '0;
      sum_d[0][SLICE-1:0]   = sl_s[0];
      c_d[0]                = sl_co[0];
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k]                   = vld_q[k-1];
        a_d[k]                     = a_q[k-1];
        b_d[k]                     = b_q[k-1];
        sum_d[k]                   = sum_q[k-1];
        sum_d[k][k*SLICE +: SLICE] = sl_s[k];
        c_d[k]                     = sl_co[k];
      end
      ovf_d = sl_co[STAGES-1] ^ sl_cm[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  // The last rank's operand copies and the inner-MSB carries of lower slices have no reader.
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], sl_cm};

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed table, streaming, back-pressure and async reset on the
// 32/8 configuration, plus a strided sweep of an 8/4 instance.

module tb_cla_adder_pipe;
  localparam int LAT  = 3;  // edges after the accepting edge until out_valid (STAGES-1)
  localparam int SLAT = 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [31:0] in_a, in_b, out_sum;
  logic        s_in_valid, s_in_ready, s_in_cin, s_in_sub, s_out_valid, s_out_ready, s_out_cout, s_out_ovf;
  logic [7:0]  s_in_a, s_in_b, s_out_sum;

  logic [33:0] drv_exp, held, r32;
  logic [33:0] exp_q[$];
  logic [9:0]  s_exp, r8;
  logic [9:0]  s_q[$];
  bit          stall_seen;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  cla_adder_pipe #(.WIDTH(8), .SLICE(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
    .out_cout(s_out_cout), .out_ovf(s_out_ovf)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic fail_unexp(input string nm, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got output %0h, required no output", nm, act);
  endtask

  // Reference: {cout, ovf, sum}, overflow from the operand/result sign rule.
  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
    logic [31:0] bb;
    logic [32:0] full;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
    return {full[32], ovf, full[31:0]};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    return {full[8], (a[7] == b[7]) && (full[7] != a[7]), full[7:0]};
  endfunction

  task automatic set_rand_op();
    in_a    = $urandom;
    in_b    = $urandom;
    in_cin  = 1'($urandom_range(1));
    in_sub  = 1'($urandom_range(1));
    drv_exp = model32(in_a, in_b, in_cin, in_sub);
  endtask

  // Monitors look at stable values mid-cycle: what they see is what the next rising edge transfers.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_seen = 1'b0;
      exp_q.delete();
    end else begin
      if (stall_seen) check("hold", {out_valid, out_cout, out_ovf, out_sum}, {1'b1, held});
      if (out_valid && !out_ready) check("in_ready_bp", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_unexp("unexpected_output", {out_cout, out_ovf, out_sum});
        else begin
          r32 = exp_q.pop_front();
          check("result", {out_cout, out_ovf, out_sum}, r32);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
      stall_seen = out_valid && !out_ready;
      held       = {out_cout, out_ovf, out_sum};
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) s_q.delete();
    else begin
      if (s_out_valid && s_out_ready) begin
        if (s_q.size() == 0) fail_unexp("small_unexpected", {s_out_cout, s_out_ovf, s_out_sum});
        else begin
          r8 = s_q.pop_front();
          check("small_result", {s_out_cout, s_out_ovf, s_out_sum}, r8);
        end
      end
      if (s_in_valid && s_in_ready) s_q.push_back(s_exp);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   lat, vcnt, i, cyc;
    bit   acc;
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[9] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};

    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_sub = 0; out_ready = 1; drv_exp = 0;
    s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_cin = 0; s_in_sub = 0; s_out_ready = 1; s_exp = 0;

    #2;
    check("rst_state", {out_valid, out_cout, out_ovf, out_sum}, 35'd0);
    check("rst_state_small", {s_out_valid, s_out_cout, s_out_ovf, s_out_sum}, 11'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1'b1);

    foreach (vecs[k]) begin
      in_a = vecs[k].a; in_b = vecs[k].b; in_cin = vecs[k].cin; in_sub = vecs[k].sub;
      drv_exp = {vecs[k].cout, vecs[k].ovf, vecs[k].sum};
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      check("dir_latency", lat, LAT);
    end
    @(posedge clk); #1;

    vcnt = 0;
    for (int n = 0; n < 16; n++) begin
      set_rand_op();
      in_valid = 1;
      @(negedge clk);
      check("stream_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      if (out_valid) vcnt++;
    end
    in_valid = 0;
    repeat (3) begin @(posedge clk); #1; if (out_valid) vcnt++; end
    check("stream_count", vcnt, 16);
    @(posedge clk); #1;
    check("stream_drain", exp_q.size(), 0);

    i = 0; cyc = 0;
    set_rand_op();
    in_valid = 1;
    while (i < 12 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin i++; set_rand_op(); end
    end
    in_valid = 0; out_ready = 1;
    check("bp_accepted", i, 12);
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("bp_drain", exp_q.size(), 0);

    out_ready = 0; lat = 0; acc = 1;
    set_rand_op();
    in_valid = 1;
    while (acc && lat < 10) begin
      @(negedge clk); acc = in_ready;
      if (acc) begin @(posedge clk); #1; set_rand_op(); lat++; end
    end
    check("fill_count", lat, 4);
    #2 rst_n = 0; in_valid = 0;
    #1 check("rst_async", {out_valid, out_cout, out_ovf, out_sum}, 35'd0);
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);
    out_ready = 1;
    in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 0; in_sub = 0;
    drv_exp = {1'b0, 1'b0, 32'h3333_3333};
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("rst_first_latency", lat, LAT);
    @(posedge clk); #1;
    check("rst_drain", exp_q.size(), 0);

    s_in_a = 8'h9C; s_in_b = 8'h75; s_in_cin = 1; s_exp = model8(8'h9C, 8'h75, 1'b1);
    s_in_valid = 1;
    @(posedge clk); #1;
    s_in_valid = 0;
    lat = 0;
    while (!s_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("small_latency", lat, SLAT);
    @(posedge clk); #1;
    for (int a = 0; a < 256; a++) begin
      for (int bi = 0; bi < 18; bi++) begin
        for (int c = 0; c < 2; c++) begin
          s_in_a = 8'(a); s_in_b = 8'(bi * 15); s_in_cin = 1'(c);
          s_exp = model8(s_in_a, s_in_b, s_in_cin);
          s_in_valid = 1;
          @(posedge clk); #1;
        end
      end
    end
    s_in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("small_drain", s_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor; successor to the team's combinational 8-bit CLA.
- Operand width is split into SLICE-bit CLA slices, one slice per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides; sustains one operation per cycle.
- Sits between operand sources (register file, counters) and downstream datapath consumers.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a positive multiple of SLICE.
- SLICE, 8, bits per CLA slice (one pipeline stage each); must be 4, 8 or 16.
- Derived, not overridable: STAGES = WIDTH/SLICE, which is also the latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in, add mode only
- in_sub  input  1  1 = A - B (B inverted, carry-in forced to 1, in_cin ignored)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry-out of MSB (in subtract mode, 1 = no borrow)
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, out_valid, out_sum, out_cout and out_ovf are 0 immediately; all internal data registers are 0; in_ready is 1 from the first cycle after release.
- Transfers: input accepted on a clk edge with in_valid && in_ready; output consumed on an edge with out_valid && out_ready.
- Pipeline advance: global enable adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready; no input-to-output comb path for data).
- When adv=1, every stage register shifts one stage; a bubble (valid=0) shifts like data.
- When adv=0, all stages hold, including bubbles. No compaction is required.
- Stage k (k=0..STAGES-1) computes slice k, bits [k*SLICE +: SLICE]:
  - Generate/propagate per bit, 4-bit look-ahead groups inside the slice.
  - Slice carry-in = in_cin' for k=0, otherwise the registered carry from stage k-1.
  - Upper operand slices travel in skew registers.
  - Completed lower sum slices travel forward alongside them.
- Effective operands: b' = in_sub ? ~in_b : in_b; cin' = in_sub ? 1 : in_cin. The mode is captured at acceptance.
- Latency: a result accepted at edge N shows out_valid=1 after edge N+STAGES-1 when unstalled (STAGES edges through registers, the last being the output register).
- Arithmetic: {out_cout, out_sum} = in_a + b' + cin', modulo 2^(WIDTH+1). out_ovf per the signed rule above.
- Back-pressure: out_sum, out_cout and out_ovf stay stable while out_valid && !out_ready. No operation is lost or duplicated.
- Simultaneous accept and consume with a full pipeline is legal; throughput stays 1/cycle.
- Reset mid-operation: all in-flight operations are discarded with no partial output.
- STAGES=1: degenerates to a single registered CLA with latency 1.

Test Plan:
- Default params, add: A=0xFFFFFFFF, B=0x00000001, cin=0 -> after 4 cycles sum=0x00000000, cout=1, ovf=0 (carry ripples across all 4 slice registers).
- Subtract: A=0x80000000, B=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1; A=3, B=5, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Streaming: 16 back-to-back random pairs with out_ready=1 -> in_ready stays 1; results in order, one per cycle, each matching a reference model after 4-cycle latency.
- Back-pressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 whenever out_valid=1; out_sum is stable; after release, the sequence continues with no gaps, losses or duplicates.
- Reset mid-flight: drop rst_n asynchronously (not on an edge) with 3 operations in flight -> out_valid=0 immediately; after release, the first new input's result is the first output seen.
- Exhaustive small config (WIDTH=8, SLICE=4): all 2^8 x 2^8 x cin combinations, matching the team's 8-bit exhaustive sweep -> every result equals a+b+cin, latency 2.
